// File: rtl/uart_cmd_framer.sv
// Byte-level UART command framer: assembles CMD_BYTES-byte commands into a FIFO and serialises RESP_BYTES-byte responses.
// Optional checksum byte per command when UART_CMD_CHKSUM_EN is defined.
module uart_cmd_framer #(
  parameter int CMD_BYTES   = 2,
  parameter int RESP_BYTES  = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_rdy,
  input  logic [7:0]              rx_data,
  output logic                    clr_rx_rdy,
  output logic [8*CMD_BYTES-1:0]  cmd,
  output logic                    cmd_rdy,
  input  logic                    clr_cmd_rdy,
  input  logic                    send_resp,
  input  logic [8*RESP_BYTES-1:0] resp,
  output logic                    trmt,
  output logic [7:0]              tx_data,
  input  logic                    tx_done,
  output logic                    resp_busy,
  output logic                    resp_done,
  output logic                    cmd_ovf,
  output logic                    rx_tmo,
  output logic                    cmd_err
);

`ifdef UART_CMD_CHKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif
  localparam int CMD_W  = 8*CMD_BYTES;
  localparam int RESP_W = 8*RESP_BYTES;
  localparam int NBYTES = CMD_BYTES + CHK_BYTES;
  localparam int IDX_W  = $clog2(NBYTES+1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC+1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int TXI_W  = $clog2(RESP_BYTES+1);

  // ---------------- RX framing ----------------
  typedef enum logic {RX_IDLE, RX_COLLECT} rx_state_t;
  rx_state_t rx_state_q, rx_state_n;

  logic [CMD_W-1:0] asm_q, asm_n;
  logic [IDX_W-1:0] idx_q;
  logic [TMO_W-1:0] tmo_q;
  logic             last_byte, tmo_hit, complete, chk_ok, push_valid;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rx_state_q <= RX_IDLE;
    else        rx_state_q <= rx_state_n;

  always_comb begin
    rx_state_n = rx_state_q;
    case (rx_state_q)
      RX_IDLE:    if (rx_rdy && !last_byte) rx_state_n = RX_COLLECT;
      RX_COLLECT: if ((rx_rdy && last_byte) || tmo_hit) rx_state_n = RX_IDLE;
      default:    rx_state_n = RX_IDLE;
    endcase
  end

  // Every presented byte is accepted; a byte in the expiry cycle beats the timeout.
  always_comb begin
    clr_rx_rdy = rx_rdy;
    last_byte  = 1'b0;
    tmo_hit    = 1'b0;
    case (rx_state_q)
      RX_IDLE:    last_byte = (NBYTES == 1);
      RX_COLLECT: begin
        last_byte = (idx_q == IDX_W'(NBYTES-1));
        tmo_hit   = !rx_rdy && (tmo_q == TMO_W'(TIMEOUT_CYC-1));
      end
      default: ;
    endcase
    complete = rx_rdy && last_byte;
  end

  // First byte lands in the top slot; a checksum byte index has no slot.
  always_comb begin
    asm_n = asm_q;
    if (rx_state_q == RX_IDLE) begin
      asm_n = '0;
      asm_n[CMD_W-1 -: 8] = rx_data;
    end else begin
      for (int i = 1; i < CMD_BYTES; i++)
        if (idx_q == IDX_W'(i)) asm_n[CMD_W-1-8*i -: 8] = rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      asm_q <= '0;
      idx_q <= '0;
      tmo_q <= '0;
    end else if (rx_rdy) begin
      asm_q <= asm_n;
      idx_q <= (rx_state_q == RX_IDLE) ? IDX_W'(1) : idx_q + 1'b1;
      tmo_q <= '0;
    end else if (rx_state_q == RX_COLLECT) begin
      tmo_q <= tmo_hit ? '0 : tmo_q + 1'b1;
    end

`ifdef UART_CMD_CHKSUM_EN
  logic [7:0] chk_q, chk_sum;
  logic       cmd_err_q;

  assign chk_sum = (rx_state_q == RX_IDLE) ? rx_data : chk_q + rx_data;
  assign chk_ok  = (chk_sum == 8'h00);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      chk_q     <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= complete && !chk_ok;
      if (rx_rdy) chk_q <= chk_sum;
    end

  assign cmd_err = cmd_err_q;
`else
  assign chk_ok  = 1'b1;
  assign cmd_err = 1'b0;
`endif

  assign push_valid = complete && chk_ok;

  // ---------------- command FIFO ----------------
  logic [CMD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, do_push, do_pop;

  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = clr_cmd_rdy && !empty;
  assign do_push = push_valid && (!full || do_pop);
  assign cmd     = mem[rd_ptr];
  assign cmd_rdy = !empty;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      cmd_ovf <= 1'b0;
      rx_tmo  <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= asm_n;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count   <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      cmd_ovf <= push_valid && full && !do_pop;
      rx_tmo  <= tmo_hit;
    end

  // ---------------- TX response serialiser ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;
  tx_state_t tx_state_q, tx_state_n;

  logic [RESP_W-1:0] resp_q;
  logic [TXI_W-1:0]  tx_idx_q;
  logic              tx_last;

  assign tx_last = (tx_idx_q == TXI_W'(RESP_BYTES-1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tx_state_q <= TX_IDLE;
    else        tx_state_q <= tx_state_n;

  always_comb begin
    tx_state_n = tx_state_q;
    case (tx_state_q)
      TX_IDLE: if (send_resp) tx_state_n = TX_SEND;
      TX_SEND: tx_state_n = TX_WAIT;
      TX_WAIT: if (tx_done) tx_state_n = tx_last ? TX_IDLE : TX_SEND;
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_comb begin
    trmt      = (tx_state_q == TX_SEND);
    resp_busy = (tx_state_q != TX_IDLE);
    tx_data   = '0;
    for (int i = 0; i < RESP_BYTES; i++)
      if (tx_idx_q == TXI_W'(i)) tx_data = resp_q[RESP_W-1-8*i -: 8];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      resp_q    <= '0;
      tx_idx_q  <= '0;
      resp_done <= 1'b0;
    end else begin
      resp_done <= (tx_state_q == TX_WAIT) && tx_done && tx_last;
      if (tx_state_q == TX_IDLE && send_resp) begin
        resp_q   <= resp;
        tx_idx_q <= '0;
      end else if (tx_state_q == TX_WAIT && tx_done && !tx_last) begin
        tx_idx_q <= tx_idx_q + 1'b1;
      end
    end

endmodule

// File: doc/uart_cmd_framer.md
Name: uart_cmd_framer

Overview:
- Parametrised successor to the two-byte UART command wrapper.
- Assembles CMD_BYTES-byte commands, most significant byte first, from a byte-level UART core.
- Queues completed commands in a small FIFO and serialises RESP_BYTES-byte responses back through the same core.
- Adds an inter-byte timeout resync and overflow reporting, between the UART core and the command processor.

Parameters:
- CMD_BYTES, 2: bytes per command (≥1); cmd width = 8*CMD_BYTES.
- RESP_BYTES, 1: bytes per response (≥1).
- FIFO_DEPTH, 4: command queue entries (power of 2, ≥2).
- TIMEOUT_CYC, 50000: clk cycles allowed between bytes of one command.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_rdy  in  1  UART core has a received byte.
- rx_data  in  8  received byte.
- clr_rx_rdy  out  1  consume byte; combinational, same cycle as acceptance.
- cmd  out  8*CMD_BYTES  FIFO head command.
- cmd_rdy  out  1  FIFO not empty.
- clr_cmd_rdy  in  1  pop FIFO head.
- send_resp  in  1  start response transmission.
- resp  in  8*RESP_BYTES  response word, sampled on accepted send_resp.
- trmt  out  1  1-cycle start pulse to the UART transmitter.
- tx_data  out  8  byte being transmitted.
- tx_done  in  1  UART transmitter finished the current byte.
- resp_busy  out  1  response in progress.
- resp_done  out  1  1-cycle pulse after the last response byte.
- cmd_ovf  out  1  1-cycle pulse: completed command dropped, FIFO full.
- rx_tmo  out  1  1-cycle pulse: partial command discarded on timeout.
- cmd_err  out  1  1-cycle pulse: checksum failure (0 without feature).

Behaviour:
- Reset: all outputs 0; FIFO empty; both FSMs in IDLE; counters 0.
- RX FSM states: IDLE, COLLECT. Byte index is 0..CMD_BYTES-1.
- IDLE, rx_rdy: accept the byte, pulse clr_rx_rdy, load the byte into the top of the assembly register, set index=1.
  - If CMD_BYTES==1, complete immediately and stay in IDLE.
  - Otherwise go to COLLECT.
- COLLECT, rx_rdy: accept the byte, pulse clr_rx_rdy, place it in the slot given by the index, clear the timeout counter.
  - On the last byte: complete, go to IDLE.
- Completion: FIFO push is registered. A last byte accepted at cycle T gives cmd_rdy=1 and cmd valid at T+1.
- Timeout: in COLLECT the counter increments each cycle without rx_rdy. At TIMEOUT_CYC-1: discard the partial command, pulse rx_tmo, return to IDLE.
  - rx_rdy in the same cycle as expiry wins: the byte is accepted and the counter cleared.
- FIFO:
  - cmd = head entry; cmd_rdy = !empty.
  - clr_cmd_rdy pops; a pop while empty is ignored.
  - Push while full with no pop: command dropped, cmd_ovf pulse, FIFO unchanged.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push and pop in the same cycle while empty: push occurs, pop ignored.
- TX FSM states: IDLE, SEND, WAIT.
- TX IDLE, send_resp: latch resp, set resp_busy=1, go to SEND.
  - send_resp while resp_busy is ignored.
- SEND: drive tx_data with the current byte, MSB byte first; pulse trmt for one cycle; go to WAIT. tx_data is held until tx_done.
- WAIT, tx_done:
  - If more bytes remain, go to SEND; the next trmt follows one cycle after tx_done.
  - Otherwise pulse resp_done, clear resp_busy, go to IDLE.
- Mid-operation reset: discards partial commands, FIFO contents and any in-progress response immediately.

Optional Feature:
- Macro: UART_CMD_CHKSUM_EN.
- Defined:
  - Each command is followed by one extra checksum byte. Valid when (sum of command bytes + checksum) mod 256 == 0.
  - Valid: push the command.
  - Invalid: discard, pulse cmd_err, no push.
  - The timeout also covers the gap before the checksum byte.
  - Completion latency is measured from the checksum byte.
- Undefined: no checksum byte is expected; cmd_err is tied to 0.

Test Plan:
- CMD_BYTES=2: bytes 0xA5, 0x3C → cmd=0xA53C, cmd_rdy rises one cycle after the second clr_rx_rdy; clr_cmd_rdy → cmd_rdy=0.
- CMD_BYTES=3, FIFO_DEPTH=4: five commands 0x010203..0x0D0E0F, no pops → four queued in order, cmd_ovf pulses once on the fifth; pops return 0x010203 first.
- Byte 0x55, then idle TIMEOUT_CYC cycles → rx_tmo pulses, no push; next bytes 0x12, 0x34 → cmd=0x1234.
- FIFO full, final byte arrives the same cycle as clr_cmd_rdy → no cmd_ovf, count stays 4, new command at the tail.
- RESP_BYTES=2, resp=0xBEEF, send_resp: trmt with tx_data=0xBE; after tx_done, trmt with 0xEF; after tx_done, resp_done pulses. A send_resp issued mid-response has no effect.
- With UART_CMD_CHKSUM_EN: 0x12, 0x34, 0xBA → cmd 0x1234 pushed. Then 0x12, 0x34, 0xBB → cmd_err pulse, no push.
